// File: rtl/timer_top.sv
// APB 64-bit free-running timer: power-of-two prescaler, 64-bit compare, maskable
// interrupt. Define TIMER_HALT_EN to build in THCSR and the debugger halt.
module timer_top (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tim_psel,
    input  logic        tim_penable,
    input  logic        tim_pwrite,
    input  logic [11:0] tim_paddr,
    input  logic [31:0] tim_pwdata,
    input  logic [3:0]  tim_pstrb,
    output logic [31:0] tim_prdata,
    output logic        tim_pready,
    output logic        tim_pslverr,
    input  logic        dbg_mode,
    output logic        tim_int
);
    localparam logic [11:0] A_TCR   = 12'h000;
    localparam logic [11:0] A_TDR0  = 12'h004;
    localparam logic [11:0] A_TDR1  = 12'h008;
    localparam logic [11:0] A_TCMP0 = 12'h00C;
    localparam logic [11:0] A_TCMP1 = 12'h010;
    localparam logic [11:0] A_TIER  = 12'h014;
    localparam logic [11:0] A_TISR  = 12'h018;
    localparam logic [11:0] A_THCSR = 12'h01C;

    logic        pready;
    logic        timer_en, div_en;
    logic [3:0]  div_val;
    logic [63:0] cnt, cmp;
    logic        int_en, int_st;
    logic [7:0]  div_cnt;
    logic        halt_ack;
    logic        access, wr, tcr_bad, tcr_wr;
    logic        new_en, new_den;
    logic [3:0]  new_dv;
    logic [8:0]  per;
    logic        tick, cnt_en;
    logic [31:0] rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    assign access = tim_psel & tim_penable;
    assign wr     = access & pready & tim_pwrite;

    // Candidate TCR fields after byte-strobe merge, used to vet the write.
    assign new_en  = tim_pstrb[0] ? tim_pwdata[0]    : timer_en;
    assign new_den = tim_pstrb[0] ? tim_pwdata[1]    : div_en;
    assign new_dv  = tim_pstrb[1] ? tim_pwdata[11:8] : div_val;
    assign tcr_bad = (new_dv > 4'd8) |
                     (timer_en & ((new_den != div_en) | (new_dv != div_val)));
    assign tcr_wr  = wr & (tim_paddr == A_TCR) & ~tcr_bad;

    assign tim_pready  = pready;
    assign tim_pslverr = wr & (tim_paddr == A_TCR) & tcr_bad;
    assign tim_prdata  = pready ? rdata : 32'd0;
    assign tim_int     = int_en & int_st;

`ifdef TIMER_HALT_EN
    logic halt_req;
    assign halt_ack = halt_req & dbg_mode;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            halt_req <= 1'b0;
        else if (wr && tim_paddr == A_THCSR && tim_pstrb[0])
            halt_req <= tim_pwdata[0] & dbg_mode;
    end
`else
    logic unused_dbg;
    assign unused_dbg = dbg_mode;
    assign halt_ack   = 1'b0;
`endif

    assign cnt_en = timer_en & ~halt_ack;
    assign per    = 9'd1 << div_val;
    assign tick   = ~div_en | (div_val == 4'd0) | ({1'b0, div_cnt} == per - 9'd1);

    always_comb begin
        rdata = 32'd0;
        case (tim_paddr)
            A_TCR:   rdata = {20'd0, div_val, 6'd0, div_en, timer_en};
            A_TDR0:  rdata = cnt[31:0];
            A_TDR1:  rdata = cnt[63:32];
            A_TCMP0: rdata = cmp[31:0];
            A_TCMP1: rdata = cmp[63:32];
            A_TIER:  rdata = {31'd0, int_en};
            A_TISR:  rdata = {31'd0, int_st};
`ifdef TIMER_HALT_EN
            A_THCSR: rdata = {30'd0, halt_ack, halt_req};
`endif
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pready   <= 1'b0;
            timer_en <= 1'b0;
            div_en   <= 1'b0;
            div_val  <= 4'd1;
            cmp      <= '1;
            int_en   <= 1'b0;
            int_st   <= 1'b0;
        end else begin
            pready <= access & ~pready;
            if (tcr_wr) begin
                timer_en <= new_en;
                div_en   <= new_den;
                div_val  <= new_dv;
            end
            if (wr && tim_paddr == A_TCMP0) cmp[31:0]  <= merge(cmp[31:0], tim_pwdata, tim_pstrb);
            if (wr && tim_paddr == A_TCMP1) cmp[63:32] <= merge(cmp[63:32], tim_pwdata, tim_pstrb);
            if (wr && tim_paddr == A_TIER && tim_pstrb[0]) int_en <= tim_pwdata[0];
            // A compare hit in the same cycle as a W1C keeps the flag set.
            if (cnt == cmp)
                int_st <= 1'b1;
            else if (wr && tim_paddr == A_TISR && tim_pstrb[0] && tim_pwdata[0])
                int_st <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            div_cnt <= 8'd0;
        else if (!cnt_en || tcr_wr || tick)
            div_cnt <= 8'd0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= 64'd0;
        end else if (wr && (tim_paddr == A_TDR0 || tim_paddr == A_TDR1)) begin
            if (tim_paddr == A_TDR0) cnt[31:0]  <= merge(cnt[31:0], tim_pwdata, tim_pstrb);
            else                     cnt[63:32] <= merge(cnt[63:32], tim_pwdata, tim_pstrb);
        end else if (tcr_wr && timer_en && !new_en) begin
            cnt <= 64'd0;
        end else if (cnt_en && tick) begin
            cnt <= cnt + 64'd1;
        end
    end
endmodule

// File: tb/tb_timer_top.sv
// Randomized directed bench for timer_top; expected counts come from an
// event-anchored arithmetic model (base + elapsed/period).
module tb_timer_top;
    localparam logic [11:0] A_TCR   = 12'h000;
    localparam logic [11:0] A_TDR0  = 12'h004;
    localparam logic [11:0] A_TDR1  = 12'h008;
    localparam logic [11:0] A_TCMP0 = 12'h00C;
    localparam logic [11:0] A_TCMP1 = 12'h010;
    localparam logic [11:0] A_TIER  = 12'h014;
    localparam logic [11:0] A_TISR  = 12'h018;
    localparam logic [11:0] A_THCSR = 12'h01C;
`ifdef TIMER_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        tim_psel, tim_penable, tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata;
    logic        tim_pready, tim_pslverr;
    logic        dbg_mode;
    logic        tim_int;

    timer_top dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
        .dbg_mode(dbg_mode), .tim_int(tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Model: count after edge t = m_base + (t - m_start) / m_per while running.
    logic [31:0] m_tcr;
    logic [63:0] m_base;
    int          m_start, m_per;
    bit          m_run, m_halt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] exp_cnt(input int t);
        if (!m_run) return m_base;
        return m_base + 64'((t - m_start) / m_per);
    endfunction

    // One APB transfer; ce is the commit edge, prdata is sampled at edge ce-1.
    task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic err,
                       output int ce);
        tim_psel = 1; tim_penable = 0; tim_pwrite = w;
        tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
        @(posedge sys_clk); #1 tim_penable = 1;
        @(posedge sys_clk); #1;
        chk("pready", tim_pready, 1);
        rd = tim_prdata; err = tim_pslverr;
        @(posedge sys_clk); #1;
        ce = cyc;
        tim_psel = 0; tim_penable = 0; tim_pwrite = 0;
        chk("pready_done", tim_pready, 0);
    endtask

    task automatic rd_reg(input logic [11:0] a, output logic [31:0] rd, output int re);
        logic e;
        int   ce;
        apb(1'b0, a, 32'd0, 4'd0, rd, e, ce);
        re = ce - 1;
        chk("rd_slverr", e, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int re;
        rd_reg(a, rd, re);
        chk(tag, rd, exp);
    endtask

    task automatic rd_cnt(input bit hi);
        logic [31:0] rd;
        logic [63:0] ev;
        int re;
        rd_reg(hi ? A_TDR1 : A_TDR0, rd, re);
        ev = exp_cnt(re);
        chk(hi ? "tdr1" : "tdr0", rd, hi ? ev[63:32] : ev[31:0]);
    endtask

    task automatic wr_reg(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_err, output int ce);
        logic [31:0] rd;
        logic err;
        apb(1'b1, a, d, s, rd, err, ce);
        chk("pslverr", err, exp_err);
    endtask

    task automatic tcr_write(input logic [31:0] d);
        logic [31:0] nw;
        bit bad;
        int ce;
        nw  = d & 32'h0000_0F03;
        bad = (nw[11:8] > 4'd8) ||
              (m_tcr[0] && (nw[1] != m_tcr[1] || nw[11:8] != m_tcr[11:8]));
        wr_reg(A_TCR, d, 4'hF, bad, ce);
        if (!bad) begin
            if (m_tcr[0] && !nw[0]) begin
                m_base = 64'd0; m_run = 0;
            end else if (nw[0]) begin
                m_base  = exp_cnt(ce);
                m_start = ce;
                m_per   = (nw[1] && nw[11:8] != 0) ? (1 << nw[11:8]) : 1;
                m_run   = !m_halt;
            end
            m_tcr = nw;
        end
    endtask

    task automatic tdr_write(input bit hi, input logic [31:0] d);
        logic [63:0] nv;
        int ce;
        wr_reg(hi ? A_TDR1 : A_TDR0, d, 4'hF, 1'b0, ce);
        nv = exp_cnt(ce - 1);
        if (hi) nv[63:32] = d; else nv[31:0] = d;
        m_base = nv; m_start = ce;
    endtask

    task automatic thcsr_write(input logic [31:0] d);
        bit h;
        int ce;
        wr_reg(A_THCSR, d, 4'hF, 1'b0, ce);
        h = HALT && d[0] && dbg_mode;
        if (h && !m_halt && m_tcr[0]) begin
            m_base = exp_cnt(ce); m_run = 0;
        end else if (!h && m_halt && m_tcr[0]) begin
            m_start = ce; m_run = 1;
        end
        m_halt = h;
    endtask

    initial begin
        logic [31:0] rst_vals [8];
        logic [31:0] d, cmp1;
        logic [3:0]  s, dv;
        int          k, w, ce;
        bit          de;

        tim_psel = 0; tim_penable = 0; tim_pwrite = 0;
        tim_paddr = 0; tim_pwdata = 0; tim_pstrb = 0;
        dbg_mode = 0; sys_rst_n = 0;
        m_tcr = 32'h100; m_base = 0; m_start = 0; m_per = 1; m_run = 0; m_halt = 0;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_prdata", tim_prdata, 0);
        chk("rst_pready", tim_pready, 0);
        chk("rst_pslverr", tim_pslverr, 0);
        chk("rst_int", tim_int, 0);
        sys_rst_n = 1;
        @(posedge sys_clk); #1;

        rst_vals = '{32'h100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) rd_chk("reset_reg", 12'(i * 4), rst_vals[i]);

        // Counting under several prescale settings, then disable clears the count.
        for (int it = 0; it < 5; it++) begin
            dv = (it == 0) ? 4'd0 : 4'($urandom_range(0, 8));
            de = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            d  = {20'd0, dv, 6'd0, de, 1'b1};
            tcr_write(d);
            w = (it == 0) ? 100 : $urandom_range(20, 700);
            repeat (w) @(posedge sys_clk);
            #1;
            rd_cnt(0);
            rd_cnt(1);
            tcr_write(d & ~32'd1);
            rd_cnt(0);
            rd_cnt(1);
        end

        // Rejected TCR writes leave everything as it was.
        tcr_write(32'h900);
        rd_chk("tcr_after_bad_div", A_TCR, m_tcr);
        tcr_write(32'h101);
        tcr_write(32'h301);
        tcr_write(32'h103);
        rd_chk("tcr_after_bad_run", A_TCR, 32'h101);
        repeat ($urandom_range(5, 40)) @(posedge sys_clk);
        #1;
        rd_cnt(0);
        tcr_write(32'h100);

        // Byte strobes and unmapped space.
        wr_reg(A_TCMP0, 32'h1234_5678, 4'b0001, 1'b0, ce);
        rd_chk("tcmp0_strb", A_TCMP0, 32'hFFFF_FF78);
        d = $urandom; s = 4'($urandom_range(0, 15));
        cmp1 = mrg(32'hFFFF_FFFF, d, s);
        wr_reg(A_TCMP1, d, s, 1'b0, ce);
        rd_chk("tcmp1_strb", A_TCMP1, cmp1);
        wr_reg(A_TIER, 32'hFFFF_FFFF, 4'b1110, 1'b0, ce);
        rd_chk("tier_strb", A_TIER, 32'd0);
        wr_reg(12'h020, $urandom, 4'hF, 1'b0, ce);
        rd_chk("unmapped_20", 12'h020, 32'd0);
        rd_chk("unmapped_ffc", 12'hFFC, 32'd0);

        // Compare hit raises the interrupt exactly one edge after count == compare.
        k = $urandom_range(5, 40);
        tdr_write(0, 32'hFFFF_FFFF - 32'(k));
        tdr_write(1, 32'd0);
        wr_reg(A_TCMP0, 32'hFFFF_FFFF, 4'hF, 1'b0, ce);
        wr_reg(A_TCMP1, 32'd0, 4'hF, 1'b0, ce);
        wr_reg(A_TIER, 32'd1, 4'hF, 1'b0, ce);
        chk("int_idle", tim_int, 0);
        tcr_write(32'h001);
        repeat (k) @(posedge sys_clk);
        #1;
        chk("int_before_hit", tim_int, 0);
        @(posedge sys_clk); #1;
        chk("int_after_hit", tim_int, 1);
        rd_chk("tisr_set", A_TISR, 32'd1);
        wr_reg(A_TISR, 32'd0, 4'hF, 1'b0, ce);
        chk("int_w0_keeps", tim_int, 1);
        wr_reg(A_TISR, 32'd1, 4'hF, 1'b0, ce);
        chk("int_w1c", tim_int, 0);
        rd_chk("tisr_clr", A_TISR, 32'd0);

        // Debug halt.
        dbg_mode = 1;
        thcsr_write(32'd1);
        rd_chk("thcsr_halt", A_THCSR, HALT ? 32'd3 : 32'd0);
        repeat ($urandom_range(10, 50)) @(posedge sys_clk);
        #1;
        rd_cnt(0);
        thcsr_write(32'd0);
        rd_chk("thcsr_release", A_THCSR, 32'd0);
        repeat ($urandom_range(10, 50)) @(posedge sys_clk);
        #1;
        rd_cnt(0);
        dbg_mode = 0;
        thcsr_write(32'd1);
        rd_chk("thcsr_nodbg", A_THCSR, 32'd0);
        repeat ($urandom_range(10, 50)) @(posedge sys_clk);
        #1;
        rd_cnt(0);
        thcsr_write(32'd0);

        // Live TDR writes and 64-bit wrap.
        k = $urandom_range(10, 30);
        tdr_write(1, 32'hFFFF_FFFF);
        tdr_write(0, 32'hFFFF_FFFF - 32'(k));
        repeat (40) @(posedge sys_clk);
        #1;
        rd_cnt(1);
        rd_cnt(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
